// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per cycle: shift-add multiply, restoring divide, sign fix-up at the end.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_e;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 dbz_q, dbz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 sgn_op;
  logic                 is_div;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     acc_hi;
  logic [WIDTH-1:0]     acc_lo;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_sh;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  // op_q[0]=0 selects the signed variant, op_q[1]=1 selects divide.
  assign sgn_op = ~op_q[0];
  assign is_div = op_q[1];

  assign mag_a = (sgn_op && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b = (sgn_op && b_q[WIDTH-1]) ? -b_q : b_q;

  assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
  assign acc_lo = acc_q[WIDTH-1:0];

  // Multiply: LO half holds the remaining multiplier bits, the sum carry shifts into HI.
  assign mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mag_q : '0)};
  assign mul_next = {mul_sum, acc_lo[WIDTH-1:1]};

  // Divide: HI is the partial remainder, LO shifts dividend bits out and quotient bits in.
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, mag_q};
  assign div_diff = div_sh[WIDTH-1:0] - mag_q;
  assign div_next = div_ge ? {div_diff, acc_lo[WIDTH-2:0], 1'b1}
                           : {div_sh[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};

  assign prod_fix = neg_q  ? -acc_q  : acc_q;
  assign quo_fix  = neg_q  ? -acc_lo : acc_lo;
  assign rem_fix  = rneg_q ? -acc_hi : acc_hi;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end else if (!op[2]) begin
            op_d    = op[1:0];
            a_d     = a;
            b_d     = b;
            state_d = S_PREP;
          end
        end
      end
      S_PREP: begin
        mag_d   = mag_b;
        acc_d   = {{WIDTH{1'b0}}, mag_a};
        neg_d   = sgn_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d  = sgn_op & is_div & a_q[WIDTH-1];
        dbz_d   = is_div & (b_q == '0);
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (dbz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else if (is_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A cancel drops the whole operation, including any same-cycle MTHI/MTLO.
    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mag_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
